// File: rtl/control_unit.sv
// Hardwired Moore control sequencer for the Mini SRC datapath: fetch T0-T2, opcode-driven execute T3-T7.
// State is registered; every strobe is decoded combinationally from state and IR[31:27].
module control_unit (
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] IR,
  input  logic        Stop,
  output logic        Run,
  output logic        PCout,
  output logic        ZHighout,
  output logic        ZLowout,
  output logic        MDRout,
  output logic        HIout,
  output logic        LOout,
  output logic        InPortout,
  output logic        Cout,
  output logic        BAout,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        R_in,
  output logic        R_out,
  output logic        PC_enable,
  output logic        IR_enable,
  output logic        MAR_enable,
  output logic        MDR_enable,
  output logic        Y_enable,
  output logic        ZHighIn,
  output logic        ZLowIn,
  output logic        HI_enable,
  output logic        LO_enable,
  output logic        OutPort_enable,
  output logic        MDR_read,
  output logic        RAM_write,
  output logic        IncPC,
  output logic [3:0]  ALU_op
);
  localparam logic [4:0] OP_LD = 5'b00000, OP_LDI = 5'b00001, OP_ST = 5'b00010;
  localparam logic [4:0] OP_ADD = 5'b00011, OP_SUB = 5'b00100, OP_AND = 5'b00101, OP_OR = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100, OP_ANDI = 5'b01101, OP_ORI = 5'b01110;
  localparam logic [4:0] OP_MUL = 5'b10011, OP_DIV = 5'b10100, OP_JR = 5'b10101;
  localparam logic [4:0] OP_IN = 5'b10111, OP_OUT = 5'b11000, OP_MFHI = 5'b11001;
  localparam logic [4:0] OP_MFLO = 5'b11010, OP_HALT = 5'b11100;

  typedef enum logic [3:0] {S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT} state_t;

  state_t     state, last;
  logic       stop_pend;
  logic [4:0] op;
  logic [3:0] alu_code;
  logic       c_alu, c_imm, c_ldi, c_ld, c_st, c_md;
  logic       unused_ir;

  assign op        = IR[31:27];
  assign unused_ir = ^IR[26:0];

  assign c_alu = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  assign c_imm = (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
  assign c_ldi = (op == OP_LDI);
  assign c_ld  = (op == OP_LD);
  assign c_st  = (op == OP_ST);
  assign c_md  = (op == OP_MUL) || (op == OP_DIV);

  always_comb begin
    case (op)
      OP_SUB:          alu_code = 4'd1;
      OP_AND, OP_ANDI: alu_code = 4'd2;
      OP_OR,  OP_ORI:  alu_code = 4'd3;
      OP_MUL:          alu_code = 4'd4;
      OP_DIV:          alu_code = 4'd5;
      default:         alu_code = 4'd0;
    endcase
  end

  always_comb begin
    if (c_alu || c_imm || c_ldi) last = S_T5;
    else if (c_md)               last = S_T6;
    else if (c_ld || c_st)       last = S_T7;
    else                         last = S_T3;
  end

  // A Stop seen anywhere in an instruction is remembered until its final state.
  always_ff @(posedge Clock) begin
    if (Clear) begin
      state     <= S_RESET;
      stop_pend <= 1'b0;
    end else begin
      case (state)
        S_RESET: state <= S_T0;
        S_HALT:  state <= S_HALT;
        default: begin
          if (state == last) begin
            state     <= (op == OP_HALT || stop_pend || Stop) ? S_HALT : S_T0;
            stop_pend <= 1'b0;
          end else begin
            state     <= state_t'(state + 4'd1);
            stop_pend <= stop_pend | Stop;
          end
        end
      endcase
    end
  end

  always_comb begin
    PCout = 1'b0; ZHighout = 1'b0; ZLowout = 1'b0; MDRout = 1'b0; HIout = 1'b0;
    LOout = 1'b0; InPortout = 1'b0; Cout = 1'b0; BAout = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; R_in = 1'b0; R_out = 1'b0;
    PC_enable = 1'b0; IR_enable = 1'b0; MAR_enable = 1'b0; MDR_enable = 1'b0; Y_enable = 1'b0;
    ZHighIn = 1'b0; ZLowIn = 1'b0; HI_enable = 1'b0; LO_enable = 1'b0; OutPort_enable = 1'b0;
    MDR_read = 1'b0; RAM_write = 1'b0; IncPC = 1'b0; ALU_op = 4'd0;
    Run = (state != S_RESET) && (state != S_HALT);
    case (state)
      S_T0: begin PCout = 1'b1; MAR_enable = 1'b1; IncPC = 1'b1; ZLowIn = 1'b1; end
      S_T1: begin ZLowout = 1'b1; PC_enable = 1'b1; MDR_read = 1'b1; MDR_enable = 1'b1; end
      S_T2: begin MDRout = 1'b1; IR_enable = 1'b1; end
      S_T3: begin
        if (c_alu || c_imm)            begin Grb = 1'b1; R_out = 1'b1; Y_enable = 1'b1; end
        else if (c_ldi || c_ld || c_st) begin Grb = 1'b1; BAout = 1'b1; Y_enable = 1'b1; end
        else if (c_md)                 begin Gra = 1'b1; R_out = 1'b1; Y_enable = 1'b1; end
        else begin
          case (op)
            OP_JR:   begin Gra = 1'b1; R_out = 1'b1; PC_enable = 1'b1; end
            OP_IN:   begin InPortout = 1'b1; Gra = 1'b1; R_in = 1'b1; end
            OP_OUT:  begin Gra = 1'b1; R_out = 1'b1; OutPort_enable = 1'b1; end
            OP_MFHI: begin HIout = 1'b1; Gra = 1'b1; R_in = 1'b1; end
            OP_MFLO: begin LOout = 1'b1; Gra = 1'b1; R_in = 1'b1; end
            default: ;
          endcase
        end
      end
      S_T4: begin
        if (c_alu) begin
          Grc = 1'b1; R_out = 1'b1; ZLowIn = 1'b1; ALU_op = alu_code;
        end else if (c_imm || c_ldi || c_ld || c_st) begin
          Cout = 1'b1; ZLowIn = 1'b1; ALU_op = alu_code;
        end else if (c_md) begin
          Grb = 1'b1; R_out = 1'b1; ZHighIn = 1'b1; ZLowIn = 1'b1; ALU_op = alu_code;
        end
      end
      S_T5: begin
        if (c_alu || c_imm || c_ldi) begin ZLowout = 1'b1; Gra = 1'b1; R_in = 1'b1; end
        else if (c_ld || c_st)       begin ZLowout = 1'b1; MAR_enable = 1'b1; end
        else if (c_md)               begin ZLowout = 1'b1; LO_enable = 1'b1; end
      end
      S_T6: begin
        if (c_ld)      begin MDR_read = 1'b1; MDR_enable = 1'b1; end
        else if (c_st) begin Gra = 1'b1; R_out = 1'b1; MDR_enable = 1'b1; end
        else if (c_md) begin ZHighout = 1'b1; HI_enable = 1'b1; end
      end
      S_T7: begin
        if (c_ld)      begin MDRout = 1'b1; Gra = 1'b1; R_in = 1'b1; end
        else if (c_st) RAM_write = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: a queue-of-cycles instruction model checked every cycle,
// directed walk through the key instructions, then randomized opcodes with Stop/Clear.
module tb_control_unit;
  logic        Clock = 1'b0;
  logic        Clear = 1'b1;
  logic [31:0] IR = '0;
  logic        Stop = 1'b0;
  logic Run, PCout, ZHighout, ZLowout, MDRout, HIout, LOout, InPortout, Cout, BAout;
  logic Gra, Grb, Grc, R_in, R_out;
  logic PC_enable, IR_enable, MAR_enable, MDR_enable, Y_enable, ZHighIn, ZLowIn;
  logic HI_enable, LO_enable, OutPort_enable, MDR_read, RAM_write, IncPC;
  logic [3:0] ALU_op;

  control_unit dut (
    .Clock(Clock), .Clear(Clear), .IR(IR), .Stop(Stop), .Run(Run),
    .PCout(PCout), .ZHighout(ZHighout), .ZLowout(ZLowout), .MDRout(MDRout), .HIout(HIout),
    .LOout(LOout), .InPortout(InPortout), .Cout(Cout), .BAout(BAout),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .R_in(R_in), .R_out(R_out),
    .PC_enable(PC_enable), .IR_enable(IR_enable), .MAR_enable(MAR_enable),
    .MDR_enable(MDR_enable), .Y_enable(Y_enable), .ZHighIn(ZHighIn), .ZLowIn(ZLowIn),
    .HI_enable(HI_enable), .LO_enable(LO_enable), .OutPort_enable(OutPort_enable),
    .MDR_read(MDR_read), .RAM_write(RAM_write), .IncPC(IncPC), .ALU_op(ALU_op)
  );

  always #5 Clock = ~Clock;

  // Output vector layout, LSB first.
  localparam logic [31:0] INCPC = 32'd1 << 0,  RAMW = 32'd1 << 1,  MDRRD = 32'd1 << 2;
  localparam logic [31:0] OPEN  = 32'd1 << 3,  LOEN = 32'd1 << 4,  HIEN  = 32'd1 << 5;
  localparam logic [31:0] ZLI   = 32'd1 << 6,  ZHI  = 32'd1 << 7,  YEN   = 32'd1 << 8;
  localparam logic [31:0] MDREN = 32'd1 << 9,  MAREN = 32'd1 << 10, IREN = 32'd1 << 11;
  localparam logic [31:0] PCEN  = 32'd1 << 12, ROUT = 32'd1 << 13, RIN   = 32'd1 << 14;
  localparam logic [31:0] GRC   = 32'd1 << 15, GRB  = 32'd1 << 16, GRA   = 32'd1 << 17;
  localparam logic [31:0] BAO   = 32'd1 << 18, CO   = 32'd1 << 19, INPO  = 32'd1 << 20;
  localparam logic [31:0] LOO   = 32'd1 << 21, HIO  = 32'd1 << 22, MDRO  = 32'd1 << 23;
  localparam logic [31:0] ZLO   = 32'd1 << 24, ZHO  = 32'd1 << 25, PCO   = 32'd1 << 26;
  localparam logic [31:0] RUNB  = 32'd1 << 27;

  localparam int M_UNK = 0, M_RESET = 1, M_RUN = 2, M_HALT = 3;

  logic [4:0] valid_ops [0:18] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd12, 5'd13,
                                   5'd14, 5'd19, 5'd20, 5'd21, 5'd23, 5'd24, 5'd25, 5'd26,
                                   5'd27, 5'd28};

  int nchk = 0, npass = 0;
  int mode = M_UNK, mpos = 0, instr_no = 0;
  bit pend = 0, cur_halt = 0, directed = 1;
  logic [31:0] q[$];
  logic [31:0] dirq[$];
  logic [31:0] exp_v = '0;
  bit exp_valid = 0;
  int lens[$];
  int kcnt = 0;
  bit seen_t0 = 0;

  function automatic logic [31:0] pack();
    return {ALU_op, Run, PCout, ZHighout, ZLowout, MDRout, HIout, LOout, InPortout, Cout, BAout,
            Gra, Grb, Grc, R_in, R_out, PC_enable, IR_enable, MAR_enable, MDR_enable, Y_enable,
            ZHighIn, ZLowIn, HI_enable, LO_enable, OutPort_enable, MDR_read, RAM_write, IncPC};
  endfunction

  function automatic logic [31:0] alu(int k);
    return 32'(k) << 28;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Whole instruction as a list of per-cycle output vectors, fetch included.
  task automatic start_instr();
    logic [31:0] ir;
    logic [4:0]  op;
    if (dirq.size() > 0) ir = dirq.pop_front();
    else begin
      op = ($urandom % 4 == 0) ? 5'($urandom) : valid_ops[$urandom % 19];
      ir = {op, 27'($urandom)};
    end
    IR = ir;
    op = ir[31:27];
    cur_halt = (op == 5'd28);
    q.delete();
    q.push_back(PCO | MAREN | INCPC | ZLI);
    q.push_back(ZLO | PCEN | MDRRD | MDREN);
    q.push_back(MDRO | IREN);
    case (op)
      5'd3, 5'd4, 5'd5, 5'd6: begin
        q.push_back(GRB | ROUT | YEN);
        q.push_back(GRC | ROUT | ZLI | alu(int'(op) - 3));
        q.push_back(ZLO | GRA | RIN);
      end
      5'd12, 5'd13, 5'd14: begin
        q.push_back(GRB | ROUT | YEN);
        q.push_back(CO | ZLI | alu(op == 5'd12 ? 0 : op == 5'd13 ? 2 : 3));
        q.push_back(ZLO | GRA | RIN);
      end
      5'd1, 5'd0, 5'd2: begin
        q.push_back(GRB | BAO | YEN);
        q.push_back(CO | ZLI);
        if (op == 5'd1) q.push_back(ZLO | GRA | RIN);
        else begin
          q.push_back(ZLO | MAREN);
          if (op == 5'd0) begin q.push_back(MDRRD | MDREN); q.push_back(MDRO | GRA | RIN); end
          else begin q.push_back(GRA | ROUT | MDREN); q.push_back(RAMW); end
        end
      end
      5'd19, 5'd20: begin
        q.push_back(GRA | ROUT | YEN);
        q.push_back(GRB | ROUT | ZHI | ZLI | alu(int'(op) - 15));
        q.push_back(ZLO | LOEN);
        q.push_back(ZHO | HIEN);
      end
      5'd21:   q.push_back(GRA | ROUT | PCEN);
      5'd23:   q.push_back(INPO | GRA | RIN);
      5'd24:   q.push_back(GRA | ROUT | OPEN);
      5'd25:   q.push_back(HIO | GRA | RIN);
      5'd26:   q.push_back(LOO | GRA | RIN);
      default: q.push_back('0);
    endcase
    foreach (q[i]) q[i] = q[i] | RUNB;
    instr_no++;
    mpos = 0;
    mode = M_RUN;
  endtask

  task automatic mstep(input bit c, input bit s);
    if (c) begin
      mode = M_RESET; pend = 0; q.delete();
    end else begin
      case (mode)
        M_RESET: start_instr();
        M_RUN: begin
          if (q.size() > 1) begin
            pend = pend | s; void'(q.pop_front()); mpos++;
          end else if (cur_halt || pend || s) begin
            mode = M_HALT; pend = 0; q.delete();
          end else start_instr();
        end
        default: ;
      endcase
    end
    exp_valid = (mode != M_UNK);
    exp_v = (mode == M_RUN) ? q[0] : '0;
  endtask

  task automatic cyc(input bit c, input bit s);
    Clear = c;
    Stop = s;
    @(posedge Clock);
    #1;
    mstep(c, s);
    if (PCout && Run) begin
      if (seen_t0) lens.push_back(kcnt);
      kcnt = 1; seen_t0 = 1;
    end else if (Run) kcnt++;
    if (directed) begin
      if (instr_no == 1 && mpos == 4) check("add_t4", 32'({Grc, R_out, ZLowIn, ALU_op}), 32'h70);
      if (instr_no == 2 && mpos == 3) check("mfhi_t3", 32'({HIout, Gra, R_in}), 32'h7);
      if (instr_no == 3 && mpos == 5) check("ld_t5_mar", 32'(MAR_enable), 32'h1);
      if (instr_no == 3 && mpos == 7) check("ld_t7", 32'({MDRout, Gra, R_in}), 32'h7);
      if (instr_no == 4 && mpos == 6) check("st_t6", 32'({MDR_read, MDR_enable}), 32'h1);
      if (instr_no == 4 && mpos == 7) check("st_t7_write", 32'(RAM_write), 32'h1);
      if (instr_no == 5 && mpos == 4) check("mul_t4_alu", 32'(ALU_op), 32'h4);
      if (instr_no == 5 && mpos == 6) check("mul_t6_hi", 32'(HI_enable), 32'h1);
    end
  endtask

  always @(negedge Clock)
    if (exp_valid) check($sformatf("cycle_outputs mode%0d pos%0d", mode, mpos), pack(), exp_v);

  initial begin
    int n;
    int exp_len [5] = '{6, 4, 8, 8, 7};
    dirq = '{32'h18918000, 32'hCC800000, 32'h00800055, 32'h10800055, 32'h99180000,
             32'h18918000, 32'hE0000000, 32'h00800055};
    cyc(1, 0);
    cyc(1, 0);
    check("reset_outputs", pack(), 32'h0);
    cyc(0, 0);
    check("t0_fetch", pack(), 32'h0C000441);

    for (int i = 0; i < 100 && !(instr_no == 6 && mpos == 1); i++) cyc(0, 0);
    check("reach_add_t1", 32'(instr_no == 6 && mpos == 1), 32'h1);
    for (int i = 0; i < 5; i++)
      if (i < lens.size()) check($sformatf("instr_len%0d", i), 32'(lens[i]), 32'(exp_len[i]));
    check("len_count", 32'(lens.size() >= 5), 32'h1);

    cyc(0, 1);
    n = 0;
    while (mode != M_HALT && n < 20) begin cyc(0, 0); n++; end
    check("stop_cycles_to_halt", 32'(n), 32'd4);
    check("stop_halt_run", 32'(Run), 32'h0);
    cyc(0, 0);
    cyc(0, 0);
    check("halt_holds", pack(), 32'h0);

    cyc(1, 0);
    cyc(0, 0);
    n = 0;
    while (mode != M_HALT && n < 10) begin cyc(0, 0); n++; end
    check("halt_op_len", 32'(n), 32'd4);
    check("halt_op_run", 32'(Run), 32'h0);

    cyc(1, 0);
    cyc(0, 0);
    for (int i = 0; i < 10 && !(instr_no == 8 && mpos == 4); i++) cyc(0, 0);
    check("reach_ld_t4", 32'(instr_no == 8 && mpos == 4), 32'h1);
    cyc(1, 0);
    check("clear_mid_ld", 32'({MAR_enable, R_in, Run}), 32'h0);
    cyc(0, 0);
    directed = 0;

    for (int i = 0; i < 4000; i++)
      cyc((mode == M_HALT && $urandom % 4 == 0) || ($urandom % 200 == 0), $urandom % 30 == 0);

    @(negedge Clock);
    #1;
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
